// File: rtl/morse_tx_scheduler_pkg.sv
// Shared definitions for the Morse transmit scheduler: state encoding and
// the letter pattern/length tables for letters A..H.
package morse_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t GAP  = 2'd2;

    localparam int PATTERN_W = 12;

    // On/off pattern, MSB first; only the leading morse_len() bits are sent.
    function automatic logic [11:0] morse_pattern(input logic [2:0] letter);
        logic [11:0] pattern;
        case (letter)
            3'd0:    pattern = 12'b1011_1000_0000; // A
            3'd1:    pattern = 12'b1110_1010_1000; // B
            3'd2:    pattern = 12'b1110_1011_1010; // C
            3'd3:    pattern = 12'b1110_1010_0000; // D
            3'd4:    pattern = 12'b1000_0000_0000; // E
            3'd5:    pattern = 12'b1010_1110_1000; // F
            3'd6:    pattern = 12'b1110_1110_1000; // G
            3'd7:    pattern = 12'b1010_1010_0000; // H
            default: pattern = 12'b0000_0000_0000;
        endcase
        return pattern;
    endfunction

    // Number of significant pattern bits for each letter.
    function automatic logic [3:0] morse_len(input logic [2:0] letter);
        logic [3:0] len;
        case (letter)
            3'd0:    len = 4'd5;
            3'd1:    len = 4'd9;
            3'd2:    len = 4'd11;
            3'd3:    len = 4'd7;
            3'd4:    len = 4'd1;
            3'd5:    len = 4'd9;
            3'd6:    len = 4'd9;
            3'd7:    len = 4'd7;
            default: len = 4'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/morse_tx_scheduler_if.sv
// Request/grant handshake bundle between the two requesters and the scheduler.
interface morse_tx_scheduler_if;
    logic       Req0;
    logic [2:0] Letter0;
    logic       Req1;
    logic [2:0] Letter1;
    logic       Grant0;
    logic       Grant1;

    modport master (output Req0, Letter0, Req1, Letter1, input Grant0, Grant1);
    modport slave  (input Req0, Letter0, Req1, Letter1, output Grant0, Grant1);
endinterface

// File: rtl/morse_tx_scheduler_symbol_timer.sv
// Symbol-rate down-counter: tick marks the last cycle of each symbol.
module morse_symbol_timer #(
    parameter int TICKS = 4
) (
    input  logic clock,
    input  logic Reset,
    input  logic enable,
    input  logic load,
    output logic tick
);

    localparam int            CW     = $clog2(TICKS);
    localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);
    localparam logic [CW-1:0] ZERO   = CW'(0);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count_r;

    assign tick = enable && (count_r == ZERO);

    // Load a full symbol on request, otherwise count down and wrap on tick.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= RELOAD;
        end else if (enable) begin
            if (count_r == ZERO) begin
                count_r <= RELOAD;
            end else begin
                count_r <= count_r - ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Two-requester Morse transmit scheduler: round-robin grant, MSB-first
// pattern shift at symbol rate, then a fixed inter-letter gap.
module morse_tx_scheduler
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int GAP_SYMBOLS     = 3
) (
    input  logic                  clock,
    input  logic                  Reset,
    morse_tx_scheduler_if.slave   req_bus,
    input  logic                  Abort,
    output logic                  DotDashOut,
    output logic                  NewBitOut,
    output logic                  Busy
);

    localparam int                 TICKS    = CLOCK_FREQUENCY / 2;
    localparam int                 GAP_W    = (GAP_SYMBOLS > 1) ? $clog2(GAP_SYMBOLS + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_SYMBOLS);
    localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
    localparam bit                 HAS_GAP  = (GAP_SYMBOLS > 0);

    state_t           state_r, state_s;
    logic [11:0]      shreg_r, shreg_s;
    logic [3:0]       bits_left_r, bits_left_s;
    logic [GAP_W-1:0] gap_left_r, gap_left_s;
    logic             prio1_r, prio1_s;     // 1: requester 1 wins a tie
    logic             winner_s;
    logic [2:0]       letter_s;
    logic             load_s, grant_s, shift_s, tick_s;
    logic             grant0_s, grant1_s, dotdash_s, newbit_s, busy_s;

    morse_symbol_timer #(.TICKS(TICKS)) u_timer (
        .clock  (clock),
        .Reset  (Reset),
        .enable (state_r != IDLE),
        .load   (load_s),
        .tick   (tick_s)
    );

    assign winner_s = (req_bus.Req0 && req_bus.Req1) ? prio1_r : req_bus.Req1;
    assign letter_s = winner_s ? req_bus.Letter1 : req_bus.Letter0;

    // State and datapath registers.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            shreg_r     <= 12'd0;
            bits_left_r <= 4'd0;
            gap_left_r  <= GAP_W'(0);
            prio1_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            bits_left_r <= bits_left_s;
            gap_left_r  <= gap_left_s;
            prio1_r     <= prio1_s;
        end
    end

    // Next-state logic: arbitration in IDLE, shifting in SEND, gap countdown.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        bits_left_s = bits_left_r;
        gap_left_s  = gap_left_r;
        prio1_s     = prio1_r;
        load_s      = 1'b0;
        grant_s     = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // Abort in IDLE suppresses any grant for that cycle.
                if (!Abort && (req_bus.Req0 || req_bus.Req1)) begin
                    grant_s     = 1'b1;
                    load_s      = 1'b1;
                    shreg_s     = morse_pattern(letter_s);
                    bits_left_s = morse_len(letter_s);
                    prio1_s     = ~winner_s;
                    state_s     = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    if (bits_left_r > 4'd1) begin
                        shift_s     = 1'b1;
                        shreg_s     = {shreg_r[10:0], 1'b0};
                        bits_left_s = bits_left_r - 4'd1;
                    end else if (HAS_GAP) begin
                        gap_left_s = GAP_LOAD;
                        state_s    = GAP;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                if (Abort) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    gap_left_s = gap_left_r - GAP_ONE;
                    state_s    = (gap_left_r == GAP_ONE) ? IDLE : GAP;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        grant0_s = grant_s && !winner_s;
        grant1_s = grant_s && winner_s;
        busy_s   = (state_s != IDLE);
        if (state_s == SEND) begin
            dotdash_s = shreg_s[11];
            newbit_s  = load_s || shift_s;
        end else begin
            dotdash_s = 1'b0;
            newbit_s  = 1'b0;
        end
    end

    // Output registers; cleared asynchronously so a reset mid-letter is immediate.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            req_bus.Grant0 <= 1'b0;
            req_bus.Grant1 <= 1'b0;
            DotDashOut     <= 1'b0;
            NewBitOut      <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            req_bus.Grant0 <= grant0_s;
            req_bus.Grant1 <= grant1_s;
            DotDashOut     <= dotdash_s;
            NewBitOut      <= newbit_s;
            Busy           <= busy_s;
        end
    end

endmodule

// File: doc/morse_tx_scheduler.md
Name: morse_tx_scheduler

Overview:
- Two-requester Morse transmit scheduler for the letter encoder datapath (letters A–H, 12-bit on/off patterns, one symbol per half-second).
- A round-robin arbiter picks one requester per letter. An FSM loads the pattern, shifts it out MSB-first at symbol rate, and then inserts a fixed inter-letter gap.
- Feeds the board LED/Morse output; owns the symbol-rate timing.

Parameters:
- CLOCK_FREQUENCY, 50000000, input clock in Hz. Symbol period TICKS = CLOCK_FREQUENCY/2 cycles (localparam, must be ≥2).
- GAP_SYMBOLS, 3, number of off-symbols after each letter; 0 is legal.

Ports:
- clock  in  1  system clock
- Reset  in  1  reset
- Req0  in  1  requester 0 wants to send Letter0
- Letter0  in  3  requester 0 letter, 0=A … 7=H
- Req1  in  1  requester 1 wants to send Letter1
- Letter1  in  3  requester 1 letter
- Abort  in  1  synchronous abort of the current letter
- Grant0  out  1  one-cycle accept pulse to requester 0
- Grant1  out  1  one-cycle accept pulse to requester 1
- DotDashOut  out  1  Morse mark (1) / space (0)
- NewBitOut  out  1  one-cycle pulse when a new pattern bit appears on DotDashOut
- Busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset: Reset, asynchronous, active-high; clock clock. All outputs 0, state IDLE, RR pointer favours requester 0, all counters cleared.
- Patterns are MSB-first, with significant length in bits:
  - A 101110000000 (5)
  - B 111010101000 (9)
  - C 111010111010 (11)
  - D 111010100000 (7)
  - E 100000000000 (1)
  - F 101011101000 (9)
  - G 111011101000 (9)
  - H 101010100000 (7)
- States: IDLE, SEND, GAP.
- Request/grant handshake:
  - A requester holds Req high and Letter stable until its Grant pulses.
  - Grants are issued only from IDLE, never while Busy.
  - A request dropped before its grant is simply not served.
- IDLE: if any Req is high at edge N:
  - Arbiter: if exactly one Req is high, that requester wins. If both are high, the requester not granted last wins.
  - At edge N the winner's Grant goes to 1 for exactly one cycle.
  - The shift register loads the winner's pattern and bits_left loads its length.
  - The tick counter loads TICKS-1, the RR pointer records the winner, and state becomes SEND.
- SEND:
  - DotDashOut = shreg[11].
  - NewBitOut = 1 in the first cycle of SEND and in the cycle after each shift.
  - The tick counter decrements each cycle; tick = (count==0), and the counter reloads TICKS-1 on tick.
  - On tick with bits_left>1: shift left by 1, bits_left−1.
  - On tick with bits_left==1: if GAP_SYMBOLS>0, go to GAP with gap_left=GAP_SYMBOLS; otherwise go to IDLE.
  - Each pattern bit is visible for exactly TICKS cycles.
- GAP:
  - DotDashOut=0 and NewBitOut=0.
  - On tick: gap_left−1. When it reaches 0, go to IDLE.
- Letter duration: (len+GAP_SYMBOLS)·TICKS cycles from the first SEND cycle to the first IDLE cycle.
- Back-to-back: a request held through the end of GAP is granted on the first IDLE edge. There is one IDLE cycle between letters.
- Abort:
  - In SEND/GAP: next edge goes to IDLE with DotDashOut=0 and the RR pointer unchanged.
  - In IDLE: ignored, and no grant is issued that cycle.
- Reset mid-letter: outputs clear immediately (async), with no residual pulse after release.
- Letter values are 3 bits, so all are valid. The default table entry of 0 with length 1 exists only for synthesis completeness.

Decomposition:
- Package morse_pkg holds:
  - Letter code table, function morse_pattern(letter)→[11:0]
  - Length table, function morse_len(letter)→[3:0]
  - State encoding localparams IDLE/SEND/GAP
- Sub-module morse_symbol_timer:
  - Down-counter parameterised by TICKS.
  - Inputs: clock, Reset, load (reload TICKS-1).
  - Output: tick.
  - Counts only while enabled (state≠IDLE).

Test Plan (CLOCK_FREQUENCY=8 ⇒ TICKS=4, GAP_SYMBOLS=3 unless noted):
- E from requester 0: Req0=1, Letter0=4 from IDLE. Response:
  - Grant0 pulses 1 cycle.
  - DotDashOut=1 for 4 cycles with a single NewBitOut pulse in the first.
  - Then DotDashOut=0 for 12 cycles.
  - Busy high for 16 cycles.
- A from requester 1: Letter1=0. DotDashOut traces 1,0,1,1,1, each bit held 4 cycles, with 5 NewBitOut pulses spaced 4 cycles. Grant0 is never asserted.
- Arbitration: Req0 and Req1 both held high from reset, with Letters D/G. Response:
  - Grant0 first; Grant1 at the first IDLE after D's gap.
  - With both still high, the next grant goes to requester 0.
  - No grant is ever asserted while Busy=1.
- Async reset: Reset pulse mid-C, at bit 6 of 11. All outputs are 0 in the same cycle, before the next edge. After release, the block idles until a new Req.
- Abort: Abort during B bit 3. Next cycle state is IDLE with DotDashOut=0 and Busy=0. A pending Req1 is granted on the following edge.
- GAP_SYMBOLS=0: two back-to-back H letters from requester 0. 7·4=28 cycles of pattern, then 1 IDLE cycle, then the second grant. Total 57 cycles from first grant to final IDLE.
